clk_count_mc: RTL and testbench

CLK_COUNT_MC -- requirements
Module: clk_count_mc

---
 rtl/clk_count_mc.sv | 125 ++++++++++++
 tb/tb_clk_count_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_count_mc.sv
// Multi-channel modulo-M counter: counts 1..M per channel with a shadow modulus that takes effect on wrap.
// Optional per-channel wrap statistics are built when CLK_COUNT_WRAP_STAT_EN is defined.
module clk_count_mc #(
  parameter int NCH     = 2,
  parameter int W       = 3,
  parameter int RST_MOD = 7,
  parameter int WRAP_CW = 8,
  localparam int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK_out,
  input  logic               rst_n,
  input  logic [NCH-1:0]     en,
  input  logic               sync_start,
  input  logic               mod_wr,
  input  logic [SW-1:0]      mod_sel,
  input  logic [W-1:0]       mod_data,
  output logic [NCH*W-1:0]   counter,
  output logic [NCH-1:0]     tc,
  output logic [NCH*W-1:0]   mod_cur
`ifdef CLK_COUNT_WRAP_STAT_EN
  ,
  output logic [NCH*WRAP_CW-1:0] wrap_cnt
`endif
);

  localparam logic [W-1:0] RST_M = W'(RST_MOD);
  localparam logic [W-1:0] ONE   = W'(1);

  if (NCH < 1 || NCH > 8 || W < 2 || W > 16 || WRAP_CW < 1) begin : g_bad_params
    $error("clk_count_mc: parameter out of range");
  end

  logic [W-1:0]   cnt_q [NCH];
  logic [W-1:0]   cnt_d [NCH];
  logic [W-1:0]   act_q [NCH];
  logic [W-1:0]   act_d [NCH];
  logic [W-1:0]   shd_q [NCH];
  logic [W-1:0]   shd_d [NCH];
  logic [NCH-1:0] tc_q;
  logic [NCH-1:0] tc_d;
  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] wrap_ev;

  // shd_d already folds in a same-edge write, so loading from it gives the shadow bypass for free.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wr_hit[k]  = mod_wr && (mod_sel == SW'(k));
      wrap_ev[k] = !sync_start && en[k] && (act_q[k] != '0) && (cnt_q[k] >= act_q[k]);
      shd_d[k]   = wr_hit[k] ? mod_data : shd_q[k];
      cnt_d[k]   = cnt_q[k];
      act_d[k]   = act_q[k];
      if (sync_start) begin
        act_d[k] = shd_d[k];
        cnt_d[k] = (shd_d[k] != '0) ? ONE : '0;
      end else if (act_q[k] == '0) begin
        cnt_d[k] = '0;
        if (wr_hit[k]) act_d[k] = mod_data;
      end else if (wrap_ev[k]) begin
        cnt_d[k] = ONE;
        act_d[k] = shd_d[k];
      end else if (en[k]) begin
        cnt_d[k] = cnt_q[k] + ONE;
      end
      tc_d[k] = (act_d[k] != '0) && (cnt_d[k] == act_d[k]);
    end
  end

  always_ff @(posedge CLK_out or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
        act_q[k] <= RST_M;
        shd_q[k] <= RST_M;
      end
      tc_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
        act_q[k] <= act_d[k];
        shd_q[k] <= shd_d[k];
      end
      tc_q <= tc_d;
    end
  end

  always_comb begin
    counter = '0;
    mod_cur = '0;
    for (int k = 0; k < NCH; k++) begin
      counter[k*W +: W] = cnt_q[k];
      mod_cur[k*W +: W] = act_q[k];
    end
  end

  assign tc = tc_q;

`ifdef CLK_COUNT_WRAP_STAT_EN
  logic [WRAP_CW-1:0] wrap_q [NCH];
  logic [WRAP_CW-1:0] wrap_d [NCH];

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      wrap_d[k] = wrap_q[k];
      if (sync_start) wrap_d[k] = '0;
      else if (wrap_ev[k] && !(&wrap_q[k])) wrap_d[k] = wrap_q[k] + WRAP_CW'(1);
    end
  end

  always_ff @(posedge CLK_out or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) wrap_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) wrap_q[k] <= wrap_d[k];
    end
  end

  always_comb begin
    wrap_cnt = '0;
    for (int k = 0; k < NCH; k++) wrap_cnt[k*WRAP_CW +: WRAP_CW] = wrap_q[k];
  end
`else
  // Wrap statistics not built: no wrap_cnt port or state.
`endif

endmodule

// File: tb/tb_clk_count_mc.sv
// Bench for clk_count_mc: per-cycle comparison against an arithmetic channel model plus directed literal checks.
module tb_clk_count_mc;
  localparam int NCH = 2;
  localparam int W = 3;
  localparam int WCW = 2;

  logic CLK_out = 1'b0;
  logic rst_n;
  logic [NCH-1:0] en;
  logic sync_start;
  logic mod_wr;
  logic [0:0] mod_sel;
  logic [W-1:0] mod_data;
  logic [NCH*W-1:0] counter;
  logic [NCH-1:0] tc;
  logic [NCH*W-1:0] mod_cur;
`ifdef CLK_COUNT_WRAP_STAT_EN
  logic [NCH*WCW-1:0] wrap_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int m_cnt[NCH];
  int m_act[NCH];
  int m_shd[NCH];
  int m_wraps[NCH];

  clk_count_mc #(.NCH(NCH), .W(W), .RST_MOD(7), .WRAP_CW(WCW)) dut (
    .CLK_out(CLK_out), .rst_n(rst_n), .en(en), .sync_start(sync_start),
    .mod_wr(mod_wr), .mod_sel(mod_sel), .mod_data(mod_data),
    .counter(counter), .tc(tc), .mod_cur(mod_cur)
`ifdef CLK_COUNT_WRAP_STAT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  // clock / reset
  always #5 CLK_out = ~CLK_out;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: channel k counts up to its modulus, then restarts at 1 and adopts the pending modulus
  always @(posedge CLK_out or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        m_cnt[k] = 0; m_act[k] = 7; m_shd[k] = 7; m_wraps[k] = 0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        bit wr;
        int pending;
        wr = mod_wr && (int'(mod_sel) == k);
        pending = wr ? int'(mod_data) : m_shd[k];
        if (sync_start) begin
          m_act[k] = pending;
          m_cnt[k] = (pending == 0) ? 0 : 1;
          m_wraps[k] = 0;
        end else if (m_act[k] == 0) begin
          if (wr) m_act[k] = int'(mod_data);
        end else if (en[k]) begin
          if (m_cnt[k] == m_act[k]) begin
            m_cnt[k] = 1;
            m_act[k] = pending;
            if (m_wraps[k] < (1 << WCW) - 1) m_wraps[k]++;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
        if (wr) m_shd[k] = int'(mod_data);
      end
    end
  end

  // scoreboard: every falling edge, all channels
  always @(negedge CLK_out) begin
    if (cmp_on) begin
      for (int k = 0; k < NCH; k++) begin
        chk($sformatf("cnt[%0d]", k), int'(counter[k*W +: W]), m_cnt[k]);
        chk($sformatf("mod[%0d]", k), int'(mod_cur[k*W +: W]), m_act[k]);
        chk($sformatf("tc[%0d]", k), int'(tc[k]), int'(m_act[k] != 0 && m_cnt[k] == m_act[k]));
`ifdef CLK_COUNT_WRAP_STAT_EN
        chk($sformatf("wrap[%0d]", k), int'(wrap_cnt[k*WCW +: WCW]), m_wraps[k]);
`endif
      end
    end
  end

  // driver: advance n rising edges, returning 2 time units after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_out);
      #2;
    end
  endtask

  task automatic wr(input int sel, input int data);
    mod_wr = 1'b1;
    mod_sel = 1'(sel);
    mod_data = W'(data);
  endtask

  initial begin
    rst_n = 1'b0; en = '0; sync_start = 1'b0; mod_wr = 1'b0; mod_sel = '0; mod_data = '0;
    step(2);
    cmp_on = 1'b1;
    chk("rst_counter", int'(counter), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_mod_cur", int'(mod_cur), 63);

    // free run with the reset modulus of 7
    rst_n = 1'b1; en = 2'b11;
    step(7);
    chk("run_at7", int'(counter), 63);
    chk("run_tc7", int'(tc), 3);
    step(1);
    chk("run_wrap", int'(counter), 9);
    chk("run_tc_wrap", int'(tc), 0);
    step(8);
    chk("run_16", int'(counter), 18);

    // new ch0 modulus mid-count lands only on the wrap
    wr(0, 3);
    step(1);
    mod_wr = 1'b0;
    step(4);
    chk("shd_pre_wrap_cnt", int'(counter), 63);
    chk("shd_pre_wrap_mod", int'(mod_cur), 63);
    step(1);
    chk("shd_wrap_mod", int'(mod_cur), 59);
    chk("shd_wrap_cnt", int'(counter), 9);
    step(2);
    chk("m3_cnt", int'(counter), 27);
    chk("m3_tc", int'(tc), 1);
    step(1);
    chk("m3_wrap", int'(counter), 33);

    // zero modulus parks ch1, then a write of 1 revives it
    wr(1, 0);
    step(1);
    mod_wr = 1'b0; sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    chk("m0_cnt", int'(counter), 1);
    chk("m0_mod", int'(mod_cur), 3);
    chk("m0_tc", int'(tc), 0);
    step(2);
    chk("m0_hold", int'(counter), 3);
    wr(1, 1);
    step(1);
    mod_wr = 1'b0;
    chk("m1_load_mod", int'(mod_cur), 11);
    chk("m1_load_cnt", int'(counter), 1);
    step(1);
    chk("m1_first", int'(counter), 10);
    chk("m1_tc", int'(tc), 2);
    step(3);
    chk("m1_tc_hold", int'(tc), 2);

    // write on the wrap edge takes effect immediately
    step(1);
    wr(0, 5);
    step(1);
    mod_wr = 1'b0;
    chk("bypass_mod", int'(mod_cur), 13);
    chk("bypass_cnt", int'(counter), 9);

    // different phases, then sync_start with enables off
    wr(1, 6);
    step(1);
    mod_wr = 1'b0;
    chk("ph_mod", int'(mod_cur), 53);
    step(2);
    chk("ph_cnt", int'(counter), 28);
    en = 2'b00; sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
    chk("sync_cnt", int'(counter), 9);
    en = 2'b11;
    step(3);
    en = 2'b00;
    step(3);
    chk("en_hold", int'(counter), 36);
    en = 2'b11;
    step(1);
    en = 2'b00;
    step(3);
    chk("en_hold_tc_cnt", int'(counter), 45);
    chk("en_hold_tc", int'(tc), 1);
    en = 2'b11;
    step(1);
    chk("en_resume", int'(counter), 49);

    // asynchronous reset between edges
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(counter), 0);
    chk("arst_tc", int'(tc), 0);
    chk("arst_mod", int'(mod_cur), 63);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst", int'(counter), 9);
    en = 2'b10;
    step(5);
    chk("en_partial", int'(counter), 49);

    // modulus 1 on both channels: wraps every enabled edge
    en = 2'b00;
    wr(0, 1);
    step(1);
    wr(1, 1);
    step(1);
    mod_wr = 1'b0; sync_start = 1'b1;
    step(1);
    sync_start = 1'b0; en = 2'b11;
    step(6);
    chk("m1_both_cnt", int'(counter), 9);
    chk("m1_both_tc", int'(tc), 3);
`ifdef CLK_COUNT_WRAP_STAT_EN
    chk("wrap_sat", int'(wrap_cnt), 15);
`endif
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
`ifdef CLK_COUNT_WRAP_STAT_EN
    chk("wrap_clear", int'(wrap_cnt), 0);
`endif
    step(2);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
